// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// op codes, FSM state encoding and small op-decode helpers.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DIV_BUSY = 2'd2,
        ST_DONE     = 2'd3
    } md_state_e;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Handshake bus between the muldiv sequencer and the two arithmetic units.
// master = sequencer side, slave = multiplier/divider side.
interface muldiv_ctrl_if #(
    parameter int DATA_WD = 32
);
    logic                   mul_start;
    logic                   mul_signed;
    logic                   div_start;
    logic                   div_signed;
    logic                   unit_annul;
    logic [DATA_WD-1:0]     unit_op1;
    logic [DATA_WD-1:0]     unit_op2;
    logic                   mul_ready;
    logic [2*DATA_WD-1:0]   mul_result;
    logic                   div_ready;
    logic [2*DATA_WD-1:0]   div_result;

    modport master (
        output mul_start, mul_signed, div_start, div_signed, unit_annul,
        output unit_op1, unit_op2,
        input  mul_ready, mul_result, div_ready, div_result
    );

    modport slave (
        input  mul_start, mul_signed, div_start, div_signed, unit_annul,
        input  unit_op1, unit_op2,
        output mul_ready, mul_result, div_ready, div_result
    );
endinterface

// File: rtl/muldiv_ctrl_hilo_reg.sv
// Architectural HI/LO register pair. A full-pair write (unit result)
// takes priority over the single-half MTHI/MTLO writes.
module hilo_reg #(
    parameter int DATA_WD = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_pair,
    input  logic [DATA_WD-1:0] pair_hi,
    input  logic [DATA_WD-1:0] pair_lo,
    input  logic               we_hi,
    input  logic               we_lo,
    input  logic [DATA_WD-1:0] wdata,
    output logic [DATA_WD-1:0] hi,
    output logic [DATA_WD-1:0] lo
);
    logic [DATA_WD-1:0] hi_reg;
    logic [DATA_WD-1:0] lo_reg;

    // HI/LO update: pair write from a finished unit, else single-half moves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (we_pair) begin
            hi_reg <= pair_hi;
            lo_reg <= pair_lo;
        end else begin
            if (we_hi) hi_reg <= wdata;
            if (we_lo) lo_reg <= wdata;
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;
endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the shared multiplier and divider. Latches operands,
// drives start/annul to the units, stalls EX while a unit is busy, commits
// results and MTHI/MTLO into HI/LO, and times out a unit that never answers.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int DATA_WD  = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [2:0]         req_op,
    input  logic [DATA_WD-1:0] req_src1,
    input  logic [DATA_WD-1:0] req_src2,
    input  logic               ex_adv,
    input  logic               flush,
    muldiv_ctrl_if.master      unit,
    output logic               stallreq,
    output logic [DATA_WD-1:0] hi_o,
    output logic [DATA_WD-1:0] lo_o,
    output logic               wd_err
);
    localparam int WD_W = $clog2(MAX_WAIT);

    md_state_e          state_reg;
    logic [WD_W-1:0]    wd_cnt_reg;
    logic [DATA_WD-1:0] op1_reg;
    logic [DATA_WD-1:0] op2_reg;
    logic               mul_start_reg;
    logic               div_start_reg;
    logic               mul_signed_reg;
    logic               div_signed_reg;
    logic               wd_err_reg;

    logic start_mul;
    logic start_div;
    logic div_zero;
    logic in_busy;
    logic unit_ready;
    logic wd_hit;
    logic commit;
    logic we_hi;
    logic we_lo;
    logic [DATA_WD-1:0] pair_hi;
    logic [DATA_WD-1:0] pair_lo;

    // Request decode and busy-state qualifiers; only the active unit's ready counts
    always_comb begin
        start_mul  = req_valid && is_mul(req_op);
        start_div  = req_valid && is_div(req_op) && (req_src2 != '0);
        div_zero   = req_valid && is_div(req_op) && (req_src2 == '0);
        in_busy    = (state_reg == ST_MUL_BUSY) || (state_reg == ST_DIV_BUSY);
        unit_ready = ((state_reg == ST_MUL_BUSY) && unit.mul_ready) ||
                     ((state_reg == ST_DIV_BUSY) && unit.div_ready);
        wd_hit     = in_busy && (wd_cnt_reg == WD_W'(MAX_WAIT - 1));
        // flush beats a same-cycle ready: nothing is written
        commit     = unit_ready && !flush;
        we_hi      = (state_reg == ST_IDLE) && req_valid && (req_op == MD_MTHI) && ex_adv && !flush;
        we_lo      = (state_reg == ST_IDLE) && req_valid && (req_op == MD_MTLO) && ex_adv && !flush;
        pair_hi    = (state_reg == ST_MUL_BUSY) ? unit.mul_result[2*DATA_WD-1:DATA_WD]
                                                : unit.div_result[2*DATA_WD-1:DATA_WD];
        pair_lo    = (state_reg == ST_MUL_BUSY) ? unit.mul_result[DATA_WD-1:0]
                                                : unit.div_result[DATA_WD-1:0];
        // stall from the issue cycle until (not including) the ready cycle
        stallreq   = ((state_reg == ST_IDLE) && (start_mul || start_div)) ||
                     (in_busy && !unit_ready);
    end

    // Sequencer FSM with operand latch, start/signed outputs and watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            wd_cnt_reg     <= '0;
            op1_reg        <= '0;
            op2_reg        <= '0;
            mul_start_reg  <= 1'b0;
            div_start_reg  <= 1'b0;
            mul_signed_reg <= 1'b0;
            div_signed_reg <= 1'b0;
            wd_err_reg     <= 1'b0;
        end else if (flush) begin
            state_reg     <= ST_IDLE;
            mul_start_reg <= 1'b0;
            div_start_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_mul) begin
                        state_reg      <= ST_MUL_BUSY;
                        op1_reg        <= req_src1;
                        op2_reg        <= req_src2;
                        mul_signed_reg <= (req_op == MD_MULT);
                        mul_start_reg  <= 1'b1;
                        wd_cnt_reg     <= '0;
                    end else if (start_div) begin
                        state_reg      <= ST_DIV_BUSY;
                        op1_reg        <= req_src1;
                        op2_reg        <= req_src2;
                        div_signed_reg <= (req_op == MD_DIV);
                        div_start_reg  <= 1'b1;
                        wd_cnt_reg     <= '0;
                    end else if (div_zero) begin
                        // divide by zero: no unit activity, HI/LO left as they are
                        state_reg <= ST_DONE;
                    end
                end
                ST_MUL_BUSY, ST_DIV_BUSY: begin
                    if (unit_ready) begin
                        state_reg     <= ST_DONE;
                        mul_start_reg <= 1'b0;
                        div_start_reg <= 1'b0;
                    end else if (wd_hit) begin
                        state_reg     <= ST_IDLE;
                        mul_start_reg <= 1'b0;
                        div_start_reg <= 1'b0;
                        wd_err_reg    <= 1'b1;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
                    end
                end
                ST_DONE: begin
                    // the still-held instruction must not restart the unit
                    if (ex_adv) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    hilo_reg #(.DATA_WD(DATA_WD)) u_hilo (
        .clk     (clk),
        .rst     (rst),
        .we_pair (commit),
        .pair_hi (pair_hi),
        .pair_lo (pair_lo),
        .we_hi   (we_hi),
        .we_lo   (we_lo),
        .wdata   (req_src1),
        .hi      (hi_o),
        .lo      (lo_o)
    );

    assign unit.mul_start  = mul_start_reg;
    assign unit.div_start  = div_start_reg;
    assign unit.mul_signed = mul_signed_reg;
    assign unit.div_signed = div_signed_reg;
    assign unit.unit_op1   = op1_reg;
    assign unit.unit_op2   = op2_reg;
    // annul in the cycle the op is abandoned (flush or timeout without a ready)
    assign unit.unit_annul = in_busy && (flush || (wd_hit && !unit_ready));
    assign wd_err          = wd_err_reg;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; the bench plays both arithmetic units.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [2:0]    req_op;
    logic [DW-1:0] req_src1;
    logic [DW-1:0] req_src2;
    logic          ex_adv;
    logic          flush;
    logic          stallreq;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;
    logic          wd_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_ctrl_if #(.DATA_WD(DW)) bus ();

    muldiv_ctrl #(.DATA_WD(DW), .MAX_WAIT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_src1  (req_src1),
        .req_src2  (req_src2),
        .ex_adv    (ex_adv),
        .flush     (flush),
        .unit      (bus),
        .stallreq  (stallreq),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .wd_err    (wd_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid      = 1'b0;
        req_op         = MD_NONE;
        req_src1       = '0;
        req_src2       = '0;
        ex_adv         = 1'b1;
        flush          = 1'b0;
        bus.mul_ready  = 1'b0;
        bus.div_ready  = 1'b0;
        bus.mul_result = '0;
        bus.div_result = '0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                         input logic adv);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = s1;
        req_src2  = s2;
        ex_adv    = adv;
    endtask

    initial begin
        // ---- reset ----
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        chk("rst_hi", 64'(hi_o), 64'h0);
        chk("rst_lo", 64'(lo_o), 64'h0);
        chk("rst_wd_err", 64'(wd_err), 64'h0);
        chk("rst_mul_start", 64'(bus.mul_start), 64'h0);
        chk("rst_div_start", 64'(bus.div_start), 64'h0);
        chk("rst_annul", 64'(bus.unit_annul), 64'h0);
        chk("rst_op1", 64'(bus.unit_op1), 64'h0);
        chk("rst_stall", 64'(stallreq), 64'h0);
        rst = 1'b1;
        step();
        $display("reset released: hi=%h lo=%h", hi_o, lo_o);

        // ---- MTHI / MTLO to seed HI/LO ----
        issue(MD_MTHI, 32'h1234, 32'h0, 1'b1);
        #1;
        chk("mthi_stall", 64'(stallreq), 64'h0);
        step();
        chk("mthi_hi", 64'(hi_o), 64'h1234);
        chk("mthi_lo_kept", 64'(lo_o), 64'h0);
        issue(MD_MTLO, 32'h5678, 32'h0, 1'b1);
        step();
        chk("mtlo_lo", 64'(lo_o), 64'h5678);
        chk("mtlo_hi_kept", 64'(hi_o), 64'h1234);
        $display("MTHI/MTLO: hi=%h lo=%h", hi_o, lo_o);

        // ---- DIV by zero ----
        issue(MD_DIV, 32'd50, 32'd0, 1'b1);
        #1;
        chk("div0_stall", 64'(stallreq), 64'h0);
        step();
        idle_inputs();
        #1;
        chk("div0_no_start", 64'(bus.div_start), 64'h0);
        chk("div0_hi", 64'(hi_o), 64'h1234);
        chk("div0_lo", 64'(lo_o), 64'h5678);
        step();
        $display("DIV by zero: hi=%h lo=%h", hi_o, lo_o);

        // ---- MULT -3 x 5 ----
        issue(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        #1;
        chk("mult_stall_issue", 64'(stallreq), 64'h1);
        step();
        req_src1 = 32'h0;           // operand latch must hold the issued value
        #1;
        chk("mult_start", 64'(bus.mul_start), 64'h1);
        chk("mult_signed", 64'(bus.mul_signed), 64'h1);
        chk("mult_op1", 64'(bus.unit_op1), 64'hFFFF_FFFD);
        chk("mult_op2", 64'(bus.unit_op2), 64'h5);
        chk("mult_stall_busy", 64'(stallreq), 64'h1);
        step();
        bus.div_ready  = 1'b1;      // foreign ready must be ignored
        bus.div_result = 64'hAAAA_AAAA_BBBB_BBBB;
        #1;
        chk("mult_foreign_ready_stall", 64'(stallreq), 64'h1);
        step();
        bus.div_ready = 1'b0;
        #1;
        chk("mult_foreign_ready_hi", 64'(hi_o), 64'h1234);
        step();
        bus.mul_ready  = 1'b1;
        bus.mul_result = 64'hFFFF_FFFF_FFFF_FFF1;
        ex_adv         = 1'b1;
        #1;
        chk("mult_ready_stall", 64'(stallreq), 64'h0);
        step();
        idle_inputs();
        #1;
        chk("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo_o), 64'hFFFF_FFF1);
        chk("mult_done_start", 64'(bus.mul_start), 64'h0);
        step();
        $display("MULT -3 x 5: hi=%h lo=%h", hi_o, lo_o);

        // ---- DIVU 100 / 7 with DONE held ----
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
        #1;
        chk("divu_stall_issue", 64'(stallreq), 64'h1);
        step();
        chk("divu_start", 64'(bus.div_start), 64'h1);
        chk("divu_signed", 64'(bus.div_signed), 64'h0);
        repeat (31) step();
        chk("divu_stall_c32", 64'(stallreq), 64'h1);
        chk("divu_start_c32", 64'(bus.div_start), 64'h1);
        bus.div_ready  = 1'b1;
        bus.div_result = {32'd2, 32'd14};
        #1;
        chk("divu_ready_stall", 64'(stallreq), 64'h0);
        step();
        bus.div_ready = 1'b0;
        #1;
        chk("divu_hi", 64'(hi_o), 64'd2);
        chk("divu_lo", 64'(lo_o), 64'd14);
        chk("divu_done1_start", 64'(bus.div_start), 64'h0);
        chk("divu_done1_stall", 64'(stallreq), 64'h0);
        step();
        chk("divu_done2_start", 64'(bus.div_start), 64'h0);
        chk("divu_done2_stall", 64'(stallreq), 64'h0);
        idle_inputs();
        step();
        $display("DIVU 100/7: hi=%0d lo=%0d", hi_o, lo_o);

        // ---- flush at busy cycle 10 of DIV ----
        issue(MD_DIV, 32'hFFFF_FFEC, 32'd3, 1'b0);
        step();
        req_valid = 1'b0;
        #1;
        chk("flush_div_signed", 64'(bus.div_signed), 64'h1);
        repeat (9) step();
        flush = 1'b1;
        #1;
        chk("flush_div_annul", 64'(bus.unit_annul), 64'h1);
        step();
        flush = 1'b0;
        #1;
        chk("flush_div_annul_off", 64'(bus.unit_annul), 64'h0);
        chk("flush_div_start", 64'(bus.div_start), 64'h0);
        chk("flush_div_stall", 64'(stallreq), 64'h0);
        chk("flush_div_hi", 64'(hi_o), 64'd2);
        chk("flush_div_lo", 64'(lo_o), 64'd14);
        $display("flush DIV: hi=%h lo=%h", hi_o, lo_o);

        // ---- flush coincident with ready ----
        issue(MD_MULTU, 32'd7, 32'd6, 1'b0);
        step();
        req_valid = 1'b0;
        #1;
        chk("flushrdy_signed", 64'(bus.mul_signed), 64'h0);
        step();
        bus.mul_ready  = 1'b1;
        bus.mul_result = 64'd42;
        flush          = 1'b1;
        #1;
        chk("flushrdy_annul", 64'(bus.unit_annul), 64'h1);
        step();
        idle_inputs();
        #1;
        chk("flushrdy_hi", 64'(hi_o), 64'd2);
        chk("flushrdy_lo", 64'(lo_o), 64'd14);
        chk("flushrdy_start", 64'(bus.mul_start), 64'h0);
        // back in IDLE: an MTHI is accepted straight away
        issue(MD_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b1);
        #1;
        chk("mthi2_stall", 64'(stallreq), 64'h0);
        step();
        idle_inputs();
        #1;
        chk("mthi2_hi", 64'(hi_o), 64'hDEAD_BEEF);
        chk("mthi2_lo_kept", 64'(lo_o), 64'd14);
        $display("flush+ready then MTHI: hi=%h lo=%h", hi_o, lo_o);

        // ---- watchdog: divider never answers ----
        issue(MD_DIV, 32'd9, 32'd2, 1'b0);
        step();
        req_valid = 1'b0;
        repeat (62) step();
        chk("wd_c63_annul", 64'(bus.unit_annul), 64'h0);
        chk("wd_c63_err", 64'(wd_err), 64'h0);
        chk("wd_c63_stall", 64'(stallreq), 64'h1);
        step();
        chk("wd_c64_annul", 64'(bus.unit_annul), 64'h1);
        step();
        chk("wd_err_set", 64'(wd_err), 64'h1);
        chk("wd_start_off", 64'(bus.div_start), 64'h0);
        chk("wd_stall_off", 64'(stallreq), 64'h0);
        chk("wd_hi", 64'(hi_o), 64'hDEAD_BEEF);
        chk("wd_lo", 64'(lo_o), 64'd14);
        step();
        chk("wd_err_sticky", 64'(wd_err), 64'h1);
        $display("watchdog: wd_err=%0d", wd_err);

        // ---- async reset mid-MULT ----
        issue(MD_MULT, 32'd3, 32'd4, 1'b0);
        step();
        req_valid = 1'b0;
        #1;
        chk("rstmid_start", 64'(bus.mul_start), 64'h1);
        rst = 1'b0;
        #1;
        chk("rstmid_start_off", 64'(bus.mul_start), 64'h0);
        chk("rstmid_wd_err", 64'(wd_err), 64'h0);
        chk("rstmid_hi", 64'(hi_o), 64'h0);
        chk("rstmid_lo", 64'(lo_o), 64'h0);
        chk("rstmid_op1", 64'(bus.unit_op1), 64'h0);
        chk("rstmid_stall", 64'(stallreq), 64'h0);
        step();
        rst = 1'b1;
        step();
        $display("reset mid-MULT: hi=%h lo=%h wd_err=%0d", hi_o, lo_o, wd_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
